multicycle_adder: RTL and testbench

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/adder_pkg.sv | 15 +
 rtl/chunk_adder.sv | 35 +++
 rtl/multicycle_adder.sv | 160 ++++++++++++++++
 tb/tb_multicycle_adder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared encodings for the multi-cycle adder.
//   state_t : FSM states IDLE / CALC / DONE
//   OP_ADD / OP_SUB : value of the 'sub' input selecting the operation
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit ripple-carry adder built from per-bit
// full-adder equations. One instance handles one chunk per cycle.
// Ports:
//   x, y  in  W  chunk operands
//   Cin   in  1  carry into bit 0
//   s     out W  chunk sum
//   Cout  out 1  carry out of bit W-1
//   Cmsb  out 1  carry into bit W-1 (used for signed overflow)
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         Cin,
  output logic [W-1:0] s,
  output logic         Cout,
  output logic         Cmsb
);

  // w_c[i] is the carry into bit i; w_c[W] is the carry out.
  logic [W:0] w_c;

  assign w_c[0] = Cin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign s[gi]      = x[gi] ^ y[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign Cout = w_c[W];
  assign Cmsb = w_c[W-1];

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract computed CHUNK bits per cycle.
// Operands are captured in IDLE, NCHUNK = WIDTH/CHUNK cycles of CALC ripple
// the carry through one chunk each, then DONE holds the result until taken.
// WIDTH must be a multiple of CHUNK.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (ready only in IDLE)
//   a, b            WIDTH-bit operands
//   cin             carry-in (add only; sub forces carry-in 1)
//   sub             0 = add, 1 = subtract (a - b)
//   out_valid/ready result handshake (valid only in DONE)
//   sum             WIDTH-bit registered result
//   cout            add: carry out; sub: 1 = no borrow
//   ovf             signed two's-complement overflow
//   zero            sum == 0
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // One extra bit so the counter can step past the last chunk without wrapping.
  localparam int CW = $clog2(NCHUNK) + 1;
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum_next;

  // Select chunk r_k of both operands.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_k == CW'(i)) begin
        w_x = r_a[i*CHUNK +: CHUNK];
        w_y = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .W(CHUNK)
  ) u_chunk (
    .x    (w_x),
    .y    (w_y),
    .Cin  (r_carry),
    .s    (w_s),
    .Cout (w_cout),
    .Cmsb (w_cmsb)
  );

  // Sum with chunk r_k replaced; on the last chunk this is the full result,
  // which lets zero be latched in the same cycle as the final chunk.
  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_k == CW'(i)) begin
        w_sum_next[i*CHUNK +: CHUNK] = w_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            // Subtraction is a + ~b + 1; cin plays no part in that case.
            r_b        <= b ^ {WIDTH{sub}};
            r_carry    <= (sub == OP_SUB) ? 1'b1 : cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_k     <= r_k + CW'(1);
          if (r_k == LAST_K) begin
            r_cout      <= w_cout;
            // Carry into MSB differing from carry out of MSB = signed overflow.
            r_ovf       <= w_cout ^ w_cmsb;
            r_zero      <= (w_sum_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result registers are left untouched here, so they stay stable
          // for as long as the consumer stalls.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: scoreboard bench for multicycle_adder.
// Two instances: 32/8 (four chunks) and 8/8 (single chunk). The driver pushes
// the expected result (from an arithmetic reference model) when it issues an
// operation; the monitor pops and compares when out_valid rises, checks
// latency, and checks the result stays stable while out_valid is held.
module tb_multicycle_adder;

  typedef struct {
    int          dut;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        iv32, iv8, or32, or8;
  logic        ir32, ov32, co32, of32, z32;
  logic [31:0] s32;
  logic        ir8, ov8, co8, of8, z8;
  logic [7:0]  s8;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32), .zero(z32)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(int d, logic [31:0] ta, logic [31:0] tb_,
                                 logic tc, logic ts, int ecyc);
    exp_t        e;
    int          w = (d != 0) ? 8 : 32;
    logic [32:0] m = (33'h1 << w) - 33'h1;
    logic [32:0] x = {1'b0, ta} & m;
    logic [32:0] y = {1'b0, tb_} & m;
    logic [32:0] r;
    logic        sa, sb, ss;
    if (ts) begin
      r      = (x - y) & m;
      e.cout = (x >= y);
    end else begin
      r      = x + y + {32'h0, tc};
      e.cout = r[w];
      r      = r & m;
    end
    sa     = x[w-1];
    sb     = y[w-1];
    ss     = r[w-1];
    e.ovf  = ts ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    e.sum  = r[31:0];
    e.zero = (r == 33'h0);
    e.dut  = d;
    e.cyc  = ecyc;
    return e;
  endfunction

  function automatic logic ir_of(int d);
    return (d != 0) ? ir8 : ir32;
  endfunction

  function automatic logic ov_of(int d);
    return (d != 0) ? ov8 : ov32;
  endfunction

  // Monitor
  logic pv[2] = '{1'b0, 1'b0};
  exp_t ce[2];

  always @(negedge clk) begin
    logic        v[2];
    logic        r[2];
    logic [31:0] s[2];
    logic [2:0]  f[2];
    exp_t        e;
    v[0] = ov32; r[0] = ir32; s[0] = s32;          f[0] = {co32, of32, z32};
    v[1] = ov8;  r[1] = ir8;  s[1] = {24'h0, s8};  f[1] = {co8, of8, z8};
    for (int d = 0; d < 2; d++) begin
      if (v[d] && !pv[d]) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          ce[d].dut = -1;
          $display("FAIL unexpected_out_valid dut%0d: got sum %h, expected no result", d, s[d]);
        end else begin
          e = q.pop_front();
          ce[d] = e;
          chk("dut_tag", d, e.dut);
          chk("sum", s[d], e.sum);
          chk("cout_ovf_zero", {29'h0, f[d]}, {29'h0, e.cout, e.ovf, e.zero});
          chk("latency_cycle", cyc, e.cyc);
        end
      end else if (v[d] && pv[d] && ce[d].dut == d) begin
        chk("held_sum", s[d], ce[d].sum);
        chk("held_flags", {29'h0, f[d]}, {29'h0, ce[d].cout, ce[d].ovf, ce[d].zero});
      end
      if (v[d]) chk("in_ready_low_in_done", {31'h0, r[d]}, 32'h0);
      pv[d] = v[d];
    end
  end

  // Driver: issue one operation, then hold out_ready low for 'hold' cycles.
  // With 'junk' set, in_valid stays high with fresh random operands while the
  // block is busy and through the output handshake; none of it may be taken.
  task automatic op(int d, logic [31:0] ta, logic [31:0] tb_, logic tc,
                    logic ts, int hold, bit junk);
    int t = 0;
    while (!ir_of(d) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout dut%0d: got 0, expected 1", d);
      return;
    end
    a = ta; b = tb_; cin = tc; sub = ts;
    if (d != 0) iv8 = 1'b1; else iv32 = 1'b1;
    q.push_back(model(d, ta, tb_, tc, ts, cyc + 1 + ((d != 0) ? 1 : 4)));
    @(negedge clk);
    if (!junk) begin
      iv8 = 1'b0;
      iv32 = 1'b0;
    end
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    t = 0;
    while (!ov_of(d) && t < 50) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      iv8 = 1'b0;
      iv32 = 1'b0;
      $display("FAIL out_valid_timeout dut%0d: got 0, expected 1", d);
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
    end
    if (d != 0) or8 = 1'b1; else or32 = 1'b1;
    @(negedge clk);
    or8 = 1'b0; or32 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv32 = 1'b0; iv8 = 1'b0; or32 = 1'b0; or8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready32", {31'h0, ir32}, 32'h1);
    chk("reset_out_valid32", {31'h0, ov32}, 32'h0);
    chk("reset_sum32", s32, 32'h0);
    chk("reset_flags32", {29'h0, co32, of32, z32}, 32'h0);
    chk("reset_in_ready8", {31'h0, ir8}, 32'h1);
    chk("reset_out8", {23'h0, ov8, s8}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
    op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 1'b0);
    op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0);
    op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2, 1'b0);
    // Backpressure with new operands offered while busy
    op(0, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0, 3, 1'b1);
    op(0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b1, 0, 1'b0);

    // Reset during the second CALC cycle: operation must vanish
    op(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0);
    a = 32'h1357_9BDF; b = 32'h2468_ACE0; cin = 1'b1; sub = 1'b0;
    iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midcalc_reset_in_ready", {31'h0, ir32}, 32'h1);
    chk("midcalc_reset_out_valid", {31'h0, ov32}, 32'h0);
    chk("midcalc_reset_sum", s32, 32'h0);
    chk("midcalc_reset_flags", {29'h0, co32, of32, z32}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    op(0, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0, 0, 1'b0);

    // Single-chunk instance
    op(1, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0, 0, 1'b0);
    op(1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      op(1, $urandom, $urandom, 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Randomized 32-bit traffic
    for (int i = 0; i < 25; i++) begin
      op(0, $urandom, $urandom, 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (8) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
